// File: rtl/piece_sprite_renderer_if.sv
// Pixel-path bundle between VGA timing, sprite ROM and one piece renderer.
// master = surrounding VGA/ROM logic, slave = the renderer.
interface piece_sprite_renderer_if #(
  parameter int IDX_W  = 4,
  parameter int ADDR_W = 16
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              frame_start;
  logic [3:0]        piece_sel;
  logic [9:0]        src_x;
  logic [9:0]        src_y;
  logic [9:0]        dst_x;
  logic [9:0]        dst_y;
  logic              move_start;
  logic              highlight_en;
  logic [ADDR_W-1:0] rom_address;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pixel_index;
  logic              piece_on;
  logic              border_on;
  logic              move_busy;
  logic              move_done;

  modport master (
    output DrawX, DrawY, frame_start, piece_sel, src_x, src_y, dst_x, dst_y,
           move_start, highlight_en, rom_q,
    input  rom_address, pixel_index, piece_on, border_on, move_busy, move_done
  );

  modport slave (
    input  DrawX, DrawY, frame_start, piece_sel, src_x, src_y, dst_x, dst_y,
           move_start, highlight_en, rom_q,
    output rom_address, pixel_index, piece_on, border_on, move_busy, move_done
  );
endinterface

// File: rtl/piece_sprite_renderer.sv
// One chess piece drawn from a shared sprite ROM, with transparency, selection
// border and a frame-synchronous slide between two board positions.
module piece_sprite_renderer #(
  parameter int SPRITE_W        = 55,
  parameter int SPRITE_H        = 55,
  parameter int PIECE_TYPES     = 12,
  parameter int IDX_W           = 4,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ROM_LATENCY     = 1,
  parameter int ANIM_LOG2       = 4,
  parameter int BORDER          = 2,
  parameter int ADDR_W          = $clog2(PIECE_TYPES*SPRITE_W*SPRITE_H)
) (
  input logic vga_clk,
  input logic reset_n,
  piece_sprite_renderer_if.slave bus
);
  localparam int PW = 11 + ANIM_LOG2 + 2;
  localparam logic [9:0] SW10  = 10'(SPRITE_W);
  localparam logic [9:0] SH10  = 10'(SPRITE_H);
  localparam logic [9:0] BD10  = 10'(BORDER);
  localparam logic [9:0] SWB10 = 10'(SPRITE_W - BORDER);
  localparam logic [9:0] SHB10 = 10'(SPRITE_H - BORDER);
  localparam logic [ANIM_LOG2:0] STEPS = (ANIM_LOG2+1)'(2**ANIM_LOG2);

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DONE} state_t;

  state_t               r_state;
  logic [9:0]           r_cur_x, r_cur_y, r_org_x, r_org_y, r_tgt_x, r_tgt_y;
  logic [ANIM_LOG2:0]   r_step;
  logic [3:0]           r_sel;
  logic                 r_hl, r_busy, r_done;
  logic [ROM_LATENCY-1:0] r_hit_sr, r_edge_sr;
  logic [IDX_W-1:0]     r_pix;
  logic                 r_on, r_border;

  logic [ANIM_LOG2:0]   w_step_n;
  logic                 w_last;
  logic [9:0]           w_dx, w_dy;
  logic                 w_hit, w_edge;

  // org + (delta*k) >>> ANIM_LOG2 with a signed 11-bit delta, floor rounding.
  function automatic logic [9:0] interp(input logic [9:0] org, input logic [9:0] tgt,
                                        input logic [ANIM_LOG2:0] k);
    logic signed [10:0]   d;
    logic signed [PW-1:0] de, ke, p;
    d  = $signed({1'b0, tgt}) - $signed({1'b0, org});
    de = PW'(d);
    ke = PW'($signed({1'b0, k}));
    p  = de * ke;
    return org + 10'(p >>> ANIM_LOG2);
  endfunction

  assign w_step_n = r_step + (ANIM_LOG2+1)'(1);
  assign w_last   = (w_step_n == STEPS);

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cur_x <= '0; r_cur_y <= '0;
      r_org_x <= '0; r_org_y <= '0;
      r_tgt_x <= '0; r_tgt_y <= '0;
      r_step  <= '0;
      r_sel   <= '0;
      r_hl    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (bus.frame_start) begin
        r_sel <= bus.piece_sel;
        r_hl  <= bus.highlight_en;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.move_start) begin
            r_org_x <= bus.src_x; r_org_y <= bus.src_y;
            r_tgt_x <= bus.dst_x; r_tgt_y <= bus.dst_y;
            r_cur_x <= bus.src_x; r_cur_y <= bus.src_y;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_MOVE;
          end else if (bus.frame_start) begin
            r_cur_x <= bus.src_x; r_cur_y <= bus.src_y;
          end
        end
        S_MOVE: begin
          if (bus.frame_start) begin
            r_step <= w_step_n;
            if (w_last) begin
              // land exactly on the target regardless of rounding
              r_cur_x <= r_tgt_x; r_cur_y <= r_tgt_y;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur_x <= interp(r_org_x, r_tgt_x, w_step_n);
              r_cur_y <= interp(r_org_y, r_tgt_y, w_step_n);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // 10-bit wrap makes pixels left of / above the sprite look huge and miss.
  assign w_dx   = bus.DrawX - r_cur_x;
  assign w_dy   = bus.DrawY - r_cur_y;
  assign w_hit  = (w_dx < SW10) && (w_dy < SH10) && ({1'b0, r_sel} < 5'(PIECE_TYPES));
  assign w_edge = w_hit && ((w_dx < BD10) || (w_dy < BD10) || (w_dx >= SWB10) || (w_dy >= SHB10));

  assign bus.rom_address = w_hit ? ADDR_W'(32'(r_sel) * 32'(SPRITE_W*SPRITE_H)
                                          + 32'(w_dy) * 32'(SPRITE_W) + 32'(w_dx))
                                 : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hit_sr  <= '0;
      r_edge_sr <= '0;
      r_pix     <= '0;
      r_on      <= 1'b0;
      r_border  <= 1'b0;
    end else begin
      r_hit_sr  <= ROM_LATENCY'({r_hit_sr, w_hit});
      r_edge_sr <= ROM_LATENCY'({r_edge_sr, w_edge});
      r_pix     <= r_hit_sr[ROM_LATENCY-1] ? bus.rom_q : '0;
      r_on      <= r_hit_sr[ROM_LATENCY-1] && (bus.rom_q != IDX_W'(TRANSPARENT_IDX));
      r_border  <= r_edge_sr[ROM_LATENCY-1] && r_hl;
    end
  end

  assign bus.pixel_index = r_pix;
  assign bus.piece_on    = r_on;
  assign bus.border_on   = r_border;
  assign bus.move_busy   = r_busy;
  assign bus.move_done   = r_done;
endmodule

// File: tb/tb_piece_sprite_renderer.sv
// Bench for piece_sprite_renderer: ROM model, fixed vector table, random pixels
// against a reference model, and hand-written slide / reset sequences.
module tb_piece_sprite_renderer;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  piece_sprite_renderer_if bus();
  piece_sprite_renderer dut (.vga_clk(vga_clk), .reset_n(reset_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  // ROM contents: word 9195 forced transparent, everything else a simple hash.
  function automatic logic [3:0] rom_fn(input int a);
    if (a == 9195) return 4'd0;
    return 4'((a * 7 + 5) % 16);
  endfunction

  always @(posedge vga_clk) bus.rom_q <= rom_fn(int'(bus.rom_address));

  typedef struct {
    int sx, sy, sel, hl, x, y;
    int addr, pi, on, bd;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(int sx, int sy, int sel, int hl, int x, int y,
                              int addr, int pi, int on, int bd);
    vec_t v;
    v.sx = sx; v.sy = sy; v.sel = sel; v.hl = hl; v.x = x; v.y = y;
    v.addr = addr; v.pi = pi; v.on = on; v.bd = bd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference pixel model: sprite box test in screen coordinates modulo 1024.
  task automatic model_px(input int x, input int y, input int cx, input int cy,
                          input int sel, input int hl,
                          output int addr, output int pi, output int on, output int bd);
    int dx, dy, q;
    bit hit, edg;
    dx   = (((x - cx) % 1024) + 1024) % 1024;
    dy   = (((y - cy) % 1024) + 1024) % 1024;
    hit  = (dx < 55) && (dy < 55) && (sel < 12);
    addr = hit ? sel * 3025 + dy * 55 + dx : 0;
    q    = int'(rom_fn(addr));
    pi   = hit ? q : 0;
    on   = (hit && q != 0) ? 1 : 0;
    edg  = hit && (dx < 2 || dy < 2 || dx >= 53 || dy >= 53);
    bd   = (edg && hl != 0) ? 1 : 0;
  endtask

  function automatic int slide_pos(int o, int t, int k);
    int v;
    v = o + int'($floor(real'((t - o) * k) / 16.0));
    return ((v % 1024) + 1024) % 1024;
  endfunction

  task automatic frame();
    bus.frame_start = 1'b1;
    @(posedge vga_clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic move_pulse();
    bus.move_start = 1'b1;
    @(posedge vga_clk); #1;
    bus.move_start = 1'b0;
  endtask

  task automatic addr_at(input int x, input int y, output int a);
    bus.DrawX = 10'(x); bus.DrawY = 10'(y);
    #1;
    a = int'(bus.rom_address);
  endtask

  task automatic check_px(input string nm, input int x, input int y, input int cx,
                          input int cy, input int sel, input int hl);
    int ea, ep, eo, eb, a;
    model_px(x, y, cx, cy, sel, hl, ea, ep, eo, eb);
    addr_at(x, y, a);
    chk({nm, ".addr"}, a, ea);
    @(posedge vga_clk); @(posedge vga_clk); #1;
    chk({nm, ".pix"}, bus.pixel_index, ep);
    chk({nm, ".on"}, bus.piece_on, eo);
    chk({nm, ".bd"}, bus.border_on, eb);
  endtask

  // With sel 1 latched, the sprite's top-left pixel reads word 3025.
  task automatic pos_chk(input string nm, input int ex, input int ey);
    int a;
    addr_at(ex, ey, a);               chk({nm, ".corner"}, a, 3025);
    addr_at((ex + 1023) % 1024, ey, a); chk({nm, ".left"}, a, 0);
    addr_at(ex, (ey + 1023) % 1024, a); chk({nm, ".above"}, a, 0);
  endtask

  task automatic slide(input string nm, input int ox, input int oy, input int tx, input int ty);
    bus.src_x = 10'(ox); bus.src_y = 10'(oy);
    bus.dst_x = 10'(tx); bus.dst_y = 10'(ty);
    move_pulse();
    chk({nm, ".busy0"}, bus.move_busy, 1);
    for (int k = 1; k <= 16; k++) begin
      frame();
      chk($sformatf("%s.busy%0d", nm, k), bus.move_busy, (k < 16) ? 1 : 0);
      chk($sformatf("%s.done%0d", nm, k), bus.move_done, (k == 16) ? 1 : 0);
      pos_chk($sformatf("%s.pos%0d", nm, k), slide_pos(ox, tx, k), slide_pos(oy, ty, k));
    end
    @(posedge vga_clk); #1;
    chk({nm, ".done_off"}, bus.move_done, 0);
    bus.src_x = 10'(tx); bus.src_y = 10'(ty);
  endtask

  initial begin
    int a, sx, sy, sel, hl;
    tbl[0]  = mk(100, 50, 0, 0, 100,  50,     0,  5, 1, 0);
    tbl[1]  = mk(100, 50, 0, 0,  99,  50,     0,  0, 0, 0);
    tbl[2]  = mk(100, 50, 0, 0, 155,  50,     0,  0, 0, 0);
    tbl[3]  = mk(100, 50, 0, 0, 154, 104,  3024,  5, 1, 0);
    tbl[4]  = mk(200,100, 3, 1, 210, 102,  9195,  0, 0, 0);
    tbl[5]  = mk(200,100, 3, 1, 201, 120, 10176,  5, 1, 1);
    tbl[6]  = mk(200,100, 3, 1, 202, 120, 10177, 12, 1, 0);
    tbl[7]  = mk(600,450, 0, 0, 639, 479,  1634,  3, 1, 0);
    tbl[8]  = mk(600,450, 0, 0,   5, 479,     0,  0, 0, 0);
    tbl[9]  = mk(100, 50,12, 1, 110,  60,     0,  0, 0, 0);
    tbl[10] = mk(100, 50, 0, 1, 154,  60,   604,  9, 1, 1);
    tbl[11] = mk(100, 50, 0, 1, 113,  50,    13,  0, 0, 1);

    bus.DrawX = '0; bus.DrawY = '0; bus.frame_start = 1'b0; bus.piece_sel = '0;
    bus.src_x = '0; bus.src_y = '0; bus.dst_x = '0; bus.dst_y = '0;
    bus.move_start = 1'b0; bus.highlight_en = 1'b0;

    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst.addr", bus.rom_address, 0);
    chk("rst.pix", bus.pixel_index, 0);
    chk("rst.on", bus.piece_on, 0);
    chk("rst.bd", bus.border_on, 0);
    chk("rst.busy", bus.move_busy, 0);
    chk("rst.done", bus.move_done, 0);
    reset_n = 1'b1;
    @(posedge vga_clk); #1;

    // exact two-cycle latency from DrawX/DrawY to the output register
    bus.src_x = 10'd100; bus.src_y = 10'd50;
    frame();
    repeat (2) @(posedge vga_clk);
    #1;
    addr_at(100, 50, a);
    chk("lat.addr", a, 0);
    @(posedge vga_clk); #1;
    chk("lat.on_c1", bus.piece_on, 0);
    bus.DrawX = 10'd99;
    @(posedge vga_clk); #1;
    chk("lat.on_c2", bus.piece_on, 1);
    chk("lat.pix_c2", bus.pixel_index, 5);
    @(posedge vga_clk); #1;
    chk("lat.on_c3", bus.piece_on, 0);

    foreach (tbl[i]) begin
      bus.src_x = 10'(tbl[i].sx); bus.src_y = 10'(tbl[i].sy);
      bus.piece_sel = 4'(tbl[i].sel); bus.highlight_en = tbl[i].hl[0];
      frame();
      addr_at(tbl[i].x, tbl[i].y, a);
      chk($sformatf("tbl%0d.addr", i), a, tbl[i].addr);
      @(posedge vga_clk); @(posedge vga_clk); #1;
      chk($sformatf("tbl%0d.pix", i), bus.pixel_index, tbl[i].pi);
      chk($sformatf("tbl%0d.on", i), bus.piece_on, tbl[i].on);
      chk($sformatf("tbl%0d.bd", i), bus.border_on, tbl[i].bd);
    end

    for (int r = 0; r < 40; r++) begin
      sx = int'($urandom_range(0, 1023)); sy = int'($urandom_range(0, 1023));
      sel = int'($urandom_range(0, 15));  hl = int'($urandom_range(0, 1));
      bus.src_x = 10'(sx); bus.src_y = 10'(sy);
      bus.piece_sel = 4'(sel); bus.highlight_en = hl[0];
      frame();
      for (int p = 0; p < 4; p++)
        check_px($sformatf("rnd%0d_%0d", r, p),
                 (sx + int'($urandom_range(0, 60)) - 3 + 1024) % 1024,
                 (sy + int'($urandom_range(0, 60)) - 3 + 1024) % 1024, sx, sy, sel, hl);
    end

    // slides: sel 1 so the corner probe is unambiguous
    bus.piece_sel = 4'd1; bus.highlight_en = 1'b0;
    bus.src_x = '0; bus.src_y = '0;
    frame();
    slide("fwd", 0, 0, 160, 80);

    // backward slide with a second move_start mid-flight that must be ignored
    bus.dst_x = '0; bus.dst_y = '0;
    move_pulse();
    frame();
    pos_chk("bwd.pos1", 150, 75);
    bus.src_x = 10'd500; bus.src_y = 10'd400; bus.dst_x = 10'd300; bus.dst_y = 10'd300;
    move_pulse();
    chk("bwd.busy_ign", bus.move_busy, 1);
    for (int k = 2; k <= 16; k++) begin
      frame();
      chk($sformatf("bwd.done%0d", k), bus.move_done, (k == 16) ? 1 : 0);
      pos_chk($sformatf("bwd.pos%0d", k), slide_pos(160, 0, k), slide_pos(80, 0, k));
    end
    @(posedge vga_clk); #1;
    chk("bwd.done_off", bus.move_done, 0);

    slide("rnd_a", int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
    slide("rnd_b", int'($urandom_range(0, 600)), int'($urandom_range(0, 400)),
                   int'($urandom_range(0, 600)), int'($urandom_range(0, 400)));

    // reset during a slide aborts it silently
    bus.src_x = '0; bus.src_y = '0; bus.dst_x = 10'd160; bus.dst_y = 10'd80;
    move_pulse();
    repeat (5) frame();
    bus.DrawX = '0; bus.DrawY = '0;
    reset_n = 1'b0;
    #1;
    chk("mrst.busy", bus.move_busy, 0);
    chk("mrst.done", bus.move_done, 0);
    chk("mrst.pix", bus.pixel_index, 0);
    chk("mrst.on", bus.piece_on, 0);
    chk("mrst.bd", bus.border_on, 0);
    @(posedge vga_clk); #1;
    reset_n = 1'b1;
    bus.src_x = 10'd300; bus.src_y = 10'd200;
    for (int c = 0; c < 4; c++) begin
      @(posedge vga_clk); #1;
      chk($sformatf("mrst.nodone%0d", c), bus.move_done | bus.move_busy, 0);
    end
    frame();
    pos_chk("mrst.reload", 300, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/piece_sprite_renderer.md
Name: piece_sprite_renderer

Overview:
- Parametrised chess-piece sprite engine for the VGA pixel path: one instance draws one piece of any type from a shared external sprite ROM, pipelined to the ROM read latency.
- Adds per-piece type selection, a transparency key, a selection-border flag and a frame-synchronous slide animation between two board positions.
- Sits between the VGA controller (DrawX/DrawY) and the colour mapper; palette lookup stays downstream.

Parameters:
- SPRITE_W, 55, sprite width in pixels
- SPRITE_H, 55, sprite height in pixels
- PIECE_TYPES, 12, number of sprites stored back-to-back in the ROM
- IDX_W, 4, palette index width of rom_q
- TRANSPARENT_IDX, 0, index treated as background
- ROM_LATENCY, 1, vga_clk cycles from rom_address to rom_q
- ANIM_LOG2, 4, slide lasts 2**ANIM_LOG2 frames
- BORDER, 2, selection border thickness in pixels
- ADDR_W, clog2(PIECE_TYPES*SPRITE_W*SPRITE_H), derived ROM address width

Ports:
- vga_clk  in  1  pixel clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- frame_start  in  1  one-cycle pulse at start of vertical blank
- piece_sel  in  4  sprite type 0..PIECE_TYPES-1
- src_x  in  10  resting / slide-origin column
- src_y  in  10  resting / slide-origin row
- dst_x  in  10  slide destination column
- dst_y  in  10  slide destination row
- move_start  in  1  request slide src->dst
- highlight_en  in  1  enable selection border
- rom_address  out  ADDR_W  sprite ROM address
- rom_q  in  IDX_W  sprite ROM data
- pixel_index  out  IDX_W  palette index, registered
- piece_on  out  1  opaque sprite pixel, registered
- border_on  out  1  selection border pixel, registered
- move_busy  out  1  slide in progress
- move_done  out  1  one-cycle pulse when slide completes

Behaviour:
- Reset (async, reset_n=0): state IDLE; cur_x, cur_y, step, sel_q, hl_q = 0; all outputs 0 (rom_address 0, pixel_index 0, piece_on 0, border_on 0, move_busy 0, move_done 0). Reset mid-slide aborts it with no move_done.
- Position and type latch only on frame_start (no tearing): sel_q<=piece_sel, hl_q<=highlight_en.
- FSM IDLE: on frame_start cur<=src. move_start (any cycle) latches src/dst into org/tgt, step<=0, cur<=org, goes MOVE, move_busy=1.
- FSM MOVE: on each frame_start step<=step+1 and cur<=org+((tgt-org)*(step+1))>>>ANIM_LOG2, using 11-bit signed delta and arithmetic shift (truncate toward -inf). When step+1==2**ANIM_LOG2: cur<=tgt exactly, go DONE.
- FSM DONE: one cycle; move_done=1, move_busy=0, then IDLE. The caller updates src to dst before the next frame_start; otherwise the piece snaps back.
- move_start in MOVE/DONE is ignored. move_start and frame_start together in IDLE: move_start wins, cur<=org.
- Stage 0 (combinational): dx=DrawX-cur_x, dy=DrawY-cur_y (10-bit unsigned). hit = dx<SPRITE_W && dy<SPRITE_H, so wrap-around rejects pixels left of or above the sprite. Sprites partially off-screen clip naturally.
- rom_address = hit ? sel_q*SPRITE_W*SPRITE_H + dy*SPRITE_W + dx : 0.
- edge = hit && (dx<BORDER || dy<BORDER || dx>=SPRITE_W-BORDER || dy>=SPRITE_H-BORDER).
- hit and edge are delayed ROM_LATENCY cycles alongside the ROM.
- Output register, total latency ROM_LATENCY+1 cycles from DrawX/DrawY:
  - pixel_index<=hit_d ? rom_q : 0
  - piece_on<=hit_d && rom_q!=TRANSPARENT_IDX
  - border_on<=edge_d && hl_q (independent of transparency)
- sel_q >= PIECE_TYPES: hit forced 0.

Test Plan:
- Static: src=(100,50), sel=0, ROM word 0=5; after frame_start drive DrawX=100, DrawY=50 -> rom_address=0, pixel_index=5, piece_on=1 exactly 2 cycles later; DrawX=99 or 155 -> piece_on=0.
- Addressing: sel=3, DrawX=cur_x+10, DrawY=cur_y+2 -> rom_address=3*3025+2*55+10=9195; rom_q=TRANSPARENT_IDX -> piece_on=0, pixel_index=0.
- Clip/wrap: cur=(600,450), DrawX=639, DrawY=479 -> hit; DrawX=5 -> no hit; border: highlight_en=1, DrawX=cur_x+1 -> border_on=1; cur_x+2 (interior row) -> 0.
- Slide: src=(0,0), dst=(160,-wrap none: 80), move_start, 16 frame_starts -> cur_x after frame 1=10, frame 8=80, frame 16=160; move_done single pulse after frame 16; move_busy high frames 0..16.
- Backward slide: src=(160,80), dst=(0,0) -> frame 1 cur_x=150; second move_start mid-slide ignored (org/tgt unchanged).
- Reset mid-slide at frame 5 -> outputs 0, move_busy=0, no move_done; next frame_start loads src.
